// File: rtl/dram_sched_ctrl_if.sv
// Request and DRAM command bus bundle for dram_sched_ctrl.
// The slave modport is the controller side, and the master modport is the L2/PHY side.
interface dram_sched_ctrl_if #(
  parameter int ADDR_WIDTH   = 22,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    cmd_req;
  logic                    cmd_ack;
  logic [2:0]              cmd;
  logic [NUM_OF_BANKS-1:0] bank_sel;
  logic [NUM_OF_ROWS-1:0]  row_sel;
  logic [NUM_OF_COLS-1:0]  col_sel;
  logic                    done;
  logic                    done_rw;
  logic                    busy;

  modport master (
    output req_valid, req_rw, req_addr, cmd_ack,
    input  req_ready, cmd_req, cmd, bank_sel, row_sel, col_sel, done, done_rw, busy
  );
  modport slave (
    input  req_valid, req_rw, req_addr, cmd_ack,
    output req_ready, cmd_req, cmd, bank_sel, row_sel, col_sel, done, done_rw, busy
  );
endinterface

// File: rtl/dram_sched_ctrl.sv
// Open-page DRAM scheduler: request queue, per-bank open-row tracking and periodic refresh.
// Commands are ACT/RD/WR/PRE/REF and are sent over a cmd_req/cmd_ack handshake.
module dram_sched_ctrl #(
  parameter int ADDR_WIDTH     = 22,
  parameter int NUM_OF_BANKS   = 8,
  parameter int NUM_OF_ROWS    = 128,
  parameter int NUM_OF_COLS    = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int REFRESH_PERIOD = 1024
) (
  input logic              clk,
  input logic              rst,
  dram_sched_ctrl_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_OF_BANKS);
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int COL_W  = $clog2(NUM_OF_COLS);
  localparam int USED_W = BANK_W + ROW_W + COL_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(REFRESH_PERIOD);

  localparam logic [2:0] CMD_NOP = 3'b000, CMD_ACT = 3'b001, CMD_RD  = 3'b010,
                         CMD_WR  = 3'b011, CMD_PRE = 3'b100, CMD_REF = 3'b101;

  typedef struct packed {
    logic              rw;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } req_t;

  typedef enum logic [2:0] {IDLE, PRE_ALL, REF, PRE, ACT, ACCESS} state_t;

  state_t                             state, state_n;
  req_t                               fifo_mem [FIFO_DEPTH];
  req_t                               head;
  logic [PTR_W-1:0]                   wr_ptr, rd_ptr;
  logic [PTR_W:0]                     count;
  logic                               push, pop, empty, full;
  logic [NUM_OF_BANKS-1:0]            open;
  logic [NUM_OF_BANKS-1:0][ROW_W-1:0] open_row;
  logic [CNT_W-1:0]                   ref_cnt;
  logic                               ref_pend, cmd_gap, cmd_req, fire;
  logic                               done_q, done_rw_q;
  logic [2:0]                         cmd_c;
  logic [NUM_OF_BANKS-1:0]            bank_c;
  logic [NUM_OF_ROWS-1:0]             row_c;
  logic [NUM_OF_COLS-1:0]             col_c;
  logic                               unused_addr;

  assign unused_addr = ^bus.req_addr;
  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign push    = bus.req_valid && !full;
  assign head    = fifo_mem[rd_ptr];
  // cmd_gap forces one NOP cycle after every acked command.
  assign cmd_req = (state != IDLE) && !cmd_gap;
  assign fire    = cmd_req && bus.cmd_ack;
  assign pop     = fire && (state == ACCESS);

  assign bus.req_ready = !full;
  assign bus.cmd_req   = cmd_req;
  assign bus.cmd       = cmd_c;
  assign bus.bank_sel  = bank_c;
  assign bus.row_sel   = row_c;
  assign bus.col_sel   = col_c;
  assign bus.done      = done_q;
  assign bus.done_rw   = done_rw_q;
  assign bus.busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_t'({bus.req_rw, bus.req_addr[USED_W-1:0]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (ref_pend)    state_n = (|open) ? PRE_ALL : REF;
        else if (!empty) begin
          if (open[head.bank] && open_row[head.bank] == head.row) state_n = ACCESS;
          else if (open[head.bank])                               state_n = PRE;
          else                                                    state_n = ACT;
        end
      end
      PRE_ALL: if (fire) state_n = REF;
      REF:     if (fire) state_n = IDLE;
      PRE:     if (fire) state_n = ACT;
      ACT:     if (fire) state_n = ACCESS;
      ACCESS:  if (fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_c  = CMD_NOP;
    bank_c = '0;
    row_c  = '0;
    col_c  = '0;
    if (cmd_req) begin
      case (state)
        PRE_ALL: begin cmd_c = CMD_PRE; bank_c = '1; end
        REF:     begin cmd_c = CMD_REF; bank_c = '1; end
        PRE: begin
          cmd_c  = CMD_PRE;
          bank_c = NUM_OF_BANKS'(1) << head.bank;
        end
        ACT: begin
          cmd_c  = CMD_ACT;
          bank_c = NUM_OF_BANKS'(1) << head.bank;
          row_c  = NUM_OF_ROWS'(1) << head.row;
        end
        ACCESS: begin
          cmd_c  = head.rw ? CMD_WR : CMD_RD;
          bank_c = NUM_OF_BANKS'(1) << head.bank;
          col_c  = NUM_OF_COLS'(1) << head.col;
        end
        default: cmd_c = CMD_NOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open      <= '0;
      open_row  <= '0;
      ref_cnt   <= '0;
      ref_pend  <= 1'b0;
      cmd_gap   <= 1'b0;
      done_q    <= 1'b0;
      done_rw_q <= 1'b0;
    end else begin
      cmd_gap <= fire;
      done_q  <= 1'b0;
      if (fire) begin
        case (state)
          PRE_ALL: open <= '0;
          REF:     ref_pend <= 1'b0;
          PRE:     open[head.bank] <= 1'b0;
          ACT: begin
            open[head.bank]     <= 1'b1;
            open_row[head.bank] <= head.row;
          end
          ACCESS: begin
            done_q    <= 1'b1;
            done_rw_q <= head.rw;
          end
          default: ;
        endcase
      end
      // An expiry landing on the REF ack cycle must survive, so the set comes after the clear.
      if (ref_cnt == CNT_W'(REFRESH_PERIOD - 1)) begin
        ref_cnt  <= '0;
        ref_pend <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_dram_sched_ctrl.sv
// Directed bench for dram_sched_ctrl: one DUT uses the default refresh period, and a second DUT
// uses a short period for the refresh scenario. Acked commands are logged at negedge.
module tb_dram_sched_ctrl;
  localparam int AW = 22, NB = 8, NR = 128, NC = 8;
  localparam logic [2:0] C_ACT = 3'b001, C_RD = 3'b010, C_WR = 3'b011, C_PRE = 3'b100, C_REF = 3'b101;

  typedef struct {
    logic [2:0]    cmd;
    logic [NB-1:0] bank;
    logic [NR-1:0] row;
    logic [NC-1:0] col;
    int            cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst, rst2;
  int   tests = 0, fails = 0, cyc = 0;
  ev_t  log1[$], log2[$];
  logic done1[$], done2[$];
  int   done1_cyc;
  ev_t  e1, e2;

  always #5 clk = ~clk;

  dram_sched_ctrl_if #(.ADDR_WIDTH(AW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus ();
  dram_sched_ctrl_if #(.ADDR_WIDTH(AW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus2 ();

  dram_sched_ctrl #(.ADDR_WIDTH(AW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
                    .FIFO_DEPTH(4), .REFRESH_PERIOD(1024))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  dram_sched_ctrl #(.ADDR_WIDTH(AW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
                    .FIFO_DEPTH(4), .REFRESH_PERIOD(16))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

  always @(negedge clk) begin
    cyc++;
    if (bus.cmd_req && bus.cmd_ack) begin
      e1.cmd = bus.cmd; e1.bank = bus.bank_sel; e1.row = bus.row_sel; e1.col = bus.col_sel; e1.cyc = cyc;
      log1.push_back(e1);
    end
    if (bus.done) begin done1.push_back(bus.done_rw); done1_cyc = cyc; end
    if (bus2.cmd_req && bus2.cmd_ack) begin
      e2.cmd = bus2.cmd; e2.bank = bus2.bank_sel; e2.row = bus2.row_sel; e2.col = bus2.col_sel; e2.cyc = cyc;
      log2.push_back(e2);
    end
    if (bus2.done) done2.push_back(bus2.done_rw);
  end

  function automatic logic [AW-1:0] mk(input int b, input int r, input int c);
    return (AW'(b) << 10) | (AW'(r) << 3) | AW'(c);
  endfunction

  function automatic logic [146:0] pk(input ev_t e);
    return {e.cmd, e.bank, e.row, e.col};
  endfunction

  // Expected command word; a negative row/col index means that select is all-zero.
  function automatic logic [146:0] ev(input logic [2:0] c, input logic [NB-1:0] b, input int r, input int col);
    logic [NR-1:0] rr;
    logic [NC-1:0] cc;
    rr = (r >= 0) ? (NR'(1) << r) : '0;
    cc = (col >= 0) ? (NC'(1) << col) : '0;
    return {c, b, rr, cc};
  endfunction

  task automatic push(input logic rw, input logic [AW-1:0] a);
    int n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = a;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 100);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (n >= 100) begin tests++; fails++; $display("FAIL push_timeout addr %h", a); end
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done1.size() < n && k < 300) begin @(negedge clk); k++; end
    tests++;
    if (done1.size() < n) begin fails++; $display("FAIL done_timeout got %0d want %0d", done1.size(), n); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    tests++; if (bus.cmd_req !== 1'b0) begin fails++; $display("FAIL rst_cmd_req got %b want 0", bus.cmd_req); end
    tests++; if (bus.cmd !== 3'b000) begin fails++; $display("FAIL rst_cmd got %b want 000", bus.cmd); end
    tests++; if (bus.bank_sel !== 8'h00) begin fails++; $display("FAIL rst_bank got %h want 00", bus.bank_sel); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_miss_write;
    @(posedge clk); #1 bus.cmd_ack = 1'b1;
    log1.delete(); done1.delete();
    push(1'b1, mk(2, 5, 3));
    wait_done(1);
    tests++; if (log1.size() !== 2) begin fails++; $display("FAIL miss_ncmd got %0d want 2", log1.size()); end
    if (log1.size() >= 2) begin
      tests++; if (pk(log1[0]) !== ev(C_ACT, 8'h04, 5, -1)) begin fails++; $display("FAIL miss_act got %h want %h", pk(log1[0]), ev(C_ACT, 8'h04, 5, -1)); end
      tests++; if (pk(log1[1]) !== ev(C_WR, 8'h04, -1, 3)) begin fails++; $display("FAIL miss_wr got %h want %h", pk(log1[1]), ev(C_WR, 8'h04, -1, 3)); end
      tests++; if (log1[1].cyc - log1[0].cyc !== 2) begin fails++; $display("FAIL miss_gap got %0d want 2", log1[1].cyc - log1[0].cyc); end
      tests++; if (done1_cyc !== log1[1].cyc + 1) begin fails++; $display("FAIL miss_done_lat got %0d want %0d", done1_cyc, log1[1].cyc + 1); end
    end
    if (done1.size() >= 1) begin
      tests++; if (done1[0] !== 1'b1) begin fails++; $display("FAIL miss_done_rw got %b want 1", done1[0]); end
    end
  endtask

  task automatic test_hit_read;
    log1.delete(); done1.delete();
    push(1'b0, mk(2, 5, 7));
    wait_done(1);
    tests++; if (log1.size() !== 1) begin fails++; $display("FAIL hit_ncmd got %0d want 1", log1.size()); end
    if (log1.size() >= 1) begin
      tests++; if (pk(log1[0]) !== ev(C_RD, 8'h04, -1, 7)) begin fails++; $display("FAIL hit_rd got %h want %h", pk(log1[0]), ev(C_RD, 8'h04, -1, 7)); end
    end
    if (done1.size() >= 1) begin
      tests++; if (done1[0] !== 1'b0) begin fails++; $display("FAIL hit_done_rw got %b want 0", done1[0]); end
    end
  endtask

  task automatic test_conflict;
    log1.delete(); done1.delete();
    push(1'b0, mk(2, 9, 1));
    wait_done(1);
    tests++; if (log1.size() !== 3) begin fails++; $display("FAIL conf_ncmd got %0d want 3", log1.size()); end
    if (log1.size() >= 3) begin
      tests++; if (pk(log1[0]) !== ev(C_PRE, 8'h04, -1, -1)) begin fails++; $display("FAIL conf_pre got %h want %h", pk(log1[0]), ev(C_PRE, 8'h04, -1, -1)); end
      tests++; if (pk(log1[1]) !== ev(C_ACT, 8'h04, 9, -1)) begin fails++; $display("FAIL conf_act got %h want %h", pk(log1[1]), ev(C_ACT, 8'h04, 9, -1)); end
      tests++; if (pk(log1[2]) !== ev(C_RD, 8'h04, -1, 1)) begin fails++; $display("FAIL conf_rd got %h want %h", pk(log1[2]), ev(C_RD, 8'h04, -1, 1)); end
    end
    push(1'b0, mk(2, 9, 4));
    wait_done(2);
    tests++; if (log1.size() !== 4) begin fails++; $display("FAIL conf_hit_ncmd got %0d want 4", log1.size()); end
    if (log1.size() >= 4) begin
      tests++; if (pk(log1[3]) !== ev(C_RD, 8'h04, -1, 4)) begin fails++; $display("FAIL conf_hit_rd got %h want %h", pk(log1[3]), ev(C_RD, 8'h04, -1, 4)); end
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    @(posedge clk); #1 bus.cmd_ack = 1'b0;
    log1.delete(); done1.delete();
    push(1'b0, mk(4, 2, 0));
    while (!bus.cmd_req && n < 50) begin @(negedge clk); n++; end
    tests++; if (bus.cmd !== C_ACT || bus.bank_sel !== 8'h10) begin fails++; $display("FAIL rmid_act got %b/%h want 001/10", bus.cmd, bus.bank_sel); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.cmd_req !== 1'b0) begin fails++; $display("FAIL rmid_cmd_req got %b want 0", bus.cmd_req); end
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b want 1", bus.req_ready); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    @(posedge clk); #1 bus.cmd_ack = 1'b1;
    log1.delete(); done1.delete();
    push(1'b0, mk(2, 9, 6));
    wait_done(1);
    tests++; if (log1.size() !== 2) begin fails++; $display("FAIL rmid_ncmd got %0d want 2", log1.size()); end
    if (log1.size() >= 2) begin
      tests++; if (pk(log1[0]) !== ev(C_ACT, 8'h04, 9, -1)) begin fails++; $display("FAIL rmid_act2 got %h want %h", pk(log1[0]), ev(C_ACT, 8'h04, 9, -1)); end
      tests++; if (pk(log1[1]) !== ev(C_RD, 8'h04, -1, 6)) begin fails++; $display("FAIL rmid_rd got %h want %h", pk(log1[1]), ev(C_RD, 8'h04, -1, 6)); end
    end
  endtask

  task automatic test_back_to_back;
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int n;
    @(posedge clk); #1 bus.cmd_ack = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    log1.delete(); done1.delete();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1; bus.req_rw = pat[i]; bus.req_addr = mk(3, 1, i);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL b2b_full got %b want 0", bus.req_ready); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_rw = pat[4]; bus.req_addr = mk(3, 1, 4);
    repeat (3) @(negedge clk);
    tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL b2b_still_full got %b want 0", bus.req_ready); end
    tests++; if (done1.size() !== 0) begin fails++; $display("FAIL b2b_early_done got %0d want 0", done1.size()); end
    @(posedge clk); #1 bus.cmd_ack = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    wait_done(5);
    tests++; if (log1.size() !== 6) begin fails++; $display("FAIL b2b_ncmd got %0d want 6", log1.size()); end
    if (log1.size() >= 6) begin
      tests++; if (pk(log1[0]) !== ev(C_ACT, 8'h08, 1, -1)) begin fails++; $display("FAIL b2b_act got %h want %h", pk(log1[0]), ev(C_ACT, 8'h08, 1, -1)); end
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (pk(log1[i+1]) !== ev(pat[i] ? C_WR : C_RD, 8'h08, -1, i)) begin
          fails++; $display("FAIL b2b_acc%0d got %h want %h", i, pk(log1[i+1]), ev(pat[i] ? C_WR : C_RD, 8'h08, -1, i));
        end
      end
    end
    if (done1.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        tests++; if (done1[i] !== pat[i]) begin fails++; $display("FAIL b2b_done%0d got %b want %b", i, done1[i], pat[i]); end
      end
    end
  endtask

  task automatic test_refresh;
    int n;
    @(posedge clk); #1;
    bus2.cmd_ack = 1'b0; rst2 = 1'b0;
    log2.delete(); done2.delete();
    bus2.req_valid = 1'b1; bus2.req_rw = 1'b1; bus2.req_addr = mk(1, 3, 2);
    @(posedge clk); #1 bus2.req_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1 bus2.cmd_ack = 1'b1;
    n = 0;
    while (done2.size() < 1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus2.req_valid = 1'b1; bus2.req_rw = 1'b0; bus2.req_addr = mk(1, 3, 5);
    @(posedge clk); #1 bus2.req_valid = 1'b0;
    n = 0;
    while (done2.size() < 2 && n < 100) begin @(negedge clk); n++; end
    tests++; if (done2.size() < 2) begin fails++; $display("FAIL ref_done_count got %0d want 2", done2.size()); end
    tests++; if (log2.size() < 6) begin fails++; $display("FAIL ref_ncmd got %0d want 6", log2.size()); end
    if (log2.size() >= 6) begin
      tests++; if (pk(log2[0]) !== ev(C_ACT, 8'h02, 3, -1)) begin fails++; $display("FAIL ref_act got %h want %h", pk(log2[0]), ev(C_ACT, 8'h02, 3, -1)); end
      tests++; if (pk(log2[1]) !== ev(C_WR, 8'h02, -1, 2)) begin fails++; $display("FAIL ref_wr got %h want %h", pk(log2[1]), ev(C_WR, 8'h02, -1, 2)); end
      tests++; if (pk(log2[2]) !== ev(C_PRE, 8'hFF, -1, -1)) begin fails++; $display("FAIL ref_preall got %h want %h", pk(log2[2]), ev(C_PRE, 8'hFF, -1, -1)); end
      tests++; if (pk(log2[3]) !== ev(C_REF, 8'hFF, -1, -1)) begin fails++; $display("FAIL ref_ref got %h want %h", pk(log2[3]), ev(C_REF, 8'hFF, -1, -1)); end
      tests++; if (pk(log2[4]) !== ev(C_ACT, 8'h02, 3, -1)) begin fails++; $display("FAIL ref_reopen got %h want %h", pk(log2[4]), ev(C_ACT, 8'h02, 3, -1)); end
      tests++; if (pk(log2[5]) !== ev(C_RD, 8'h02, -1, 5)) begin fails++; $display("FAIL ref_rd got %h want %h", pk(log2[5]), ev(C_RD, 8'h02, -1, 5)); end
    end
    if (done2.size() >= 2) begin
      tests++; if (done2[0] !== 1'b1 || done2[1] !== 1'b0) begin fails++; $display("FAIL ref_done_rw got %b%b want 10", done2[0], done2[1]); end
    end
    @(posedge clk); #1 bus2.cmd_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.cmd_ack = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_rw = 1'b0; bus2.req_addr = '0; bus2.cmd_ack = 1'b0;
    test_reset();
    test_miss_write();
    test_hit_read();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
    test_refresh();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end
endmodule
